mul_lanes_pipe: RTL and testbench
=================================

# mul_lanes_pipe

Parametrised, pipelined multi-lane multiplier for BF16 and signed INT8 operands, the next-generation successor to the single-lane combinational-plus-output-register multiplier. Accepts LANES independent operand pairs per transaction under a valid/ready handshake, computes in a fixed 3-stage pipeline with round-to-nearest-even (BF16) or saturation (INT8), and reports per-lane and sticky exception flags. Sits between the operand fetch stage and the accumulator/writeback stage of the arithmetic datapath.

## Interface
- LANES, 4, number of parallel multiplier lanes (1..16)
- CNT_W, 16, width of completed-transaction counter
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_vld  in  1  input transaction valid
- o_rdy  out  1  block can accept input this cycle
- i_mode  in  1  0 = BF16, 1 = INT8 (shared across lanes, captured per transaction)
- i_a, i_b  in  16*LANES  lane k at [16k+15:16k]; INT8 uses bits [7:0] only
- o_vld  out  1  result valid
- i_rdy  in  1  downstream accepts result
- o_res  out  16*LANES  lane-packed results
- o_ovf, o_unf, o_exc  out  LANES  per-lane flags, qualified by o_vld
- i_sticky_clr  in  1  clears sticky flags
- o_sticky_ovf, o_sticky_unf, o_sticky_exc  out  1  OR of lane flags over all handshaken results since last clear
- o_cnt  out  CNT_W  count of handshaken results, wraps at 2^CNT_W

## Operation
- BF16 exception: either operand exponent field 0xFF -> result 0x7FC0, exc=1, ovf=unf=0.
- BF16 zero/subnormal: exponent 0x00 flushes operand to zero; product = {sign,15'b0}, no flags (unless exc).
- BF16 normal: sign = sa^sb; 8x8 mantissa product with hidden 1; normalise on bit 15; keep 8 bits, guard = next bit, sticky = OR of remaining; round to nearest, ties to even; mantissa carry-out increments exponent.
- Exponent = ea + eb - 127 + norm + round_carry, computed 10-bit signed. >= 255 -> {sign,0xFF,7'b0}, ovf=1. <= 0 -> {sign,15'b0}, unf=1.
- INT8: signed 8x8 -> 16-bit product; > 127 -> 0x007F ovf=1; < -128 -> 0xFF80 unf=1; else sign-extended to 16 bits. exc=0.
- Sticky: set on o_vld & i_rdy if any lane flag; simultaneous clear and set -> set wins.
- o_cnt increments on o_vld & i_rdy.

## Timing
- Stages: S1 unpack/classify operands, S2 multiply, S3 normalise/round/saturate/pack (output register).
- Latency 3 cycles from accepted input to o_vld with i_rdy held high; throughput 1 transaction/cycle.
- Bubble-collapsing stall: stage k advances when its valid is 0 or stage k+1 advances; S3 advances when ~o_vld | i_rdy; o_rdy = S1 can advance.
- Input accepted on i_vld & o_rdy; output consumed on o_vld & i_rdy; o_res/flags stable while o_vld & ~i_rdy.
- Capacity 3 transactions; with i_rdy low, o_rdy drops after the 3rd accept.
- Reset (any time, mid-stream): all stage valids, o_res, per-lane flags, sticky flags, o_cnt -> 0; in-flight transactions discarded; o_rdy = 1 in first cycle after reset release.

## Structure
- Package mul_pkg: MODE_BF16/MODE_INT8, BF16_BIAS = 127, BF16_QNAN = 16'h7FC0, INT8_MAX/INT8_MIN saturation words, per-stage lane record typedefs.
- Sub-module mul_lane: one lane's S1-S3 datapath registers, enables driven by top-level stall control; top instantiates LANES copies plus handshake, sticky and counter logic.

## Test plan
- BF16 0x3FC0 * 0x4000 (1.5*2.0), all lanes -> 0x4040 at cycle 3, no flags; 0x3F81*0x3F81 -> 0x3F82.
- BF16 0x7F00*0x7F00 -> 0x7F80 ovf=1; 0x0080*0x0080 -> 0x0000 unf=1; 0x7F80*0x3F80 -> 0x7FC0 exc=1; sticky flags set, cleared by i_sticky_clr.
- INT8 0x00F6*0x0007 -> 0xFFBA; 0x0080*0x0080 -> 0x007F ovf=1; 0x0010*0x00F0 -> 0xFF80 unf=1; mixed lanes in one transaction.
- Backpressure: i_rdy=0, stream 5 inputs -> 3 accepted, o_rdy=0; release -> all 5 results in order, o_cnt=5, o_res held stable while stalled.
- Alternating BF16/INT8 transactions back-to-back -> each result uses its own captured mode.
- Assert rst with 2 transactions in flight -> o_vld=0, o_cnt=0, flags 0 immediately; no stale result after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and stage records for the multi-lane BF16/INT8 multiplier.
package mul_pkg;

   localparam logic MODE_BF16 = 1'b0;
   localparam logic MODE_INT8 = 1'b1;

   localparam int BF16_BIAS = 127;
   localparam logic [15:0] BF16_QNAN = 16'h7FC0;
   localparam logic [15:0] INT8_MAX = 16'h007F;
   localparam logic [15:0] INT8_MIN = 16'hFF80;

   typedef struct packed {
      logic              sign;
      logic              exc;
      logic              zero;
      logic [7:0]        ma;
      logic [7:0]        mb;
      logic signed [9:0] esum;
   } s1_t;

   typedef struct packed {
      logic              sign;
      logic              exc;
      logic              zero;
      logic [15:0]       prod;
      logic signed [9:0] esum;
   } s2_t;

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        exc;
   } s3_t;

endpackage

// File: rtl/mul_lane.sv
// One multiplier lane: unpack, multiply, round/saturate registers.
module mul_lane
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en1,
   input  logic        en2,
   input  logic        en3,
   input  logic        mode,
   input  logic        m1,
   input  logic        m2,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] res,
   output logic        ovf,
   output logic        unf,
   output logic        exc
);

   localparam logic signed [9:0] BIAS = 10'(BF16_BIAS);

   s1_t s1_d, s1_q;
   s2_t s2_d, s2_q;
   s3_t s3_d, s3_q;

   logic [7:0] ea, eb;

   always_comb begin
      ea = a[14:7];
      eb = b[14:7];
      s1_d = '0;
      if (mode == MODE_BF16) begin
         s1_d.sign = a[15] ^ b[15];
         s1_d.exc  = (ea == 8'hFF) | (eb == 8'hFF);
         s1_d.zero = (ea == 8'h00) | (eb == 8'h00);
         s1_d.ma   = {1'b1, a[6:0]};
         s1_d.mb   = {1'b1, b[6:0]};
         s1_d.esum = $signed({2'b00, ea})
                   + $signed({2'b00, eb})
                   - BIAS;
      end else begin
         s1_d.ma = a[7:0];
         s1_d.mb = b[7:0];
      end
   end

   logic signed [15:0] p_s;

   always_comb begin
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.exc  = s1_q.exc;
      s2_d.zero = s1_q.zero;
      s2_d.esum = s1_q.esum;
      p_s = 16'($signed(s1_q.ma))
          * 16'($signed(s1_q.mb));
      if (m1 == MODE_INT8)
         s2_d.prod = p_s;
      else
         s2_d.prod = 16'(s1_q.ma) * 16'(s1_q.mb);
   end

   logic              norm, g, st, rnd, carry;
   logic [7:0]        mant;
   logic [8:0]        mr;
   logic [6:0]        frac;
   logic signed [9:0] ex;
   logic signed [15:0] ps;

   always_comb begin
      s3_d  = '0;
      norm  = s2_q.prod[15];
      mant  = norm ? s2_q.prod[15:8]
                   : s2_q.prod[14:7];
      g     = norm ? s2_q.prod[7]
                   : s2_q.prod[6];
      st    = norm ? |s2_q.prod[6:0]
                   : |s2_q.prod[5:0];
      rnd   = g & (st | mant[0]);
      mr    = {1'b0, mant} + {8'b0, rnd};
      carry = mr[8];
      // mantissa overflow only happens from 0xFF, so the fraction wraps to 0
      frac  = carry ? 7'b0 : mr[6:0];
      ex    = s2_q.esum
            + $signed({9'b0, norm})
            + $signed({9'b0, carry});
      ps    = $signed(s2_q.prod);
      if (m2 == MODE_INT8) begin
         if (ps > 16'sd127) begin
            s3_d.res = INT8_MAX;
            s3_d.ovf = 1'b1;
         end else if (ps < -16'sd128) begin
            s3_d.res = INT8_MIN;
            s3_d.unf = 1'b1;
         end else begin
            s3_d.res = s2_q.prod;
         end
      end else if (s2_q.exc) begin
         s3_d.res = BF16_QNAN;
         s3_d.exc = 1'b1;
      end else if (s2_q.zero) begin
         s3_d.res = {s2_q.sign, 15'b0};
      end else if (ex >= 10'sd255) begin
         s3_d.res = {s2_q.sign, 8'hFF, 7'b0};
         s3_d.ovf = 1'b1;
      end else if (ex <= 10'sd0) begin
         s3_d.res = {s2_q.sign, 15'b0};
         s3_d.unf = 1'b1;
      end else begin
         s3_d.res = {s2_q.sign, ex[7:0], frac};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         if (en1) s1_q <= s1_d;
         if (en2) s2_q <= s2_d;
         if (en3) s3_q <= s3_d;
      end
   end

   assign res = s3_q.res;
   assign ovf = s3_q.ovf;
   assign unf = s3_q.unf;
   assign exc = s3_q.exc;

endmodule

// File: rtl/mul_lanes_pipe.sv
// Multi-lane BF16/INT8 multiplier: stall control, lanes, sticky flags, counter.
module mul_lanes_pipe
   import mul_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_vld,
   output logic               o_rdy,
   input  logic               i_mode,
   input  logic [16*LANES-1:0] i_a,
   input  logic [16*LANES-1:0] i_b,
   output logic               o_vld,
   input  logic               i_rdy,
   output logic [16*LANES-1:0] o_res,
   output logic [LANES-1:0]   o_ovf,
   output logic [LANES-1:0]   o_unf,
   output logic [LANES-1:0]   o_exc,
   input  logic               i_sticky_clr,
   output logic               o_sticky_ovf,
   output logic               o_sticky_unf,
   output logic               o_sticky_exc,
   output logic [CNT_W-1:0]   o_cnt
);

   logic v1, v2, v3;
   logic m1, m2;
   logic adv1, adv2, adv3;
   logic fire;

   // a stage moves when it is empty or its successor moves
   assign adv3  = ~v3 | i_rdy;
   assign adv2  = ~v2 | adv3;
   assign adv1  = ~v1 | adv2;
   assign o_rdy = adv1;
   assign o_vld = v3;
   assign fire  = v3 & i_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         m1 <= MODE_BF16;
         m2 <= MODE_BF16;
      end else begin
         if (adv1) begin
            v1 <= i_vld;
            m1 <= i_mode;
         end
         if (adv2) begin
            v2 <= v1;
            m2 <= m1;
         end
         if (adv3) v3 <= v2;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : gen_lane
      mul_lane u_lane (
         .clk  (clk),
         .rst  (rst),
         .en1  (adv1 & i_vld),
         .en2  (adv2 & v1),
         .en3  (adv3 & v2),
         .mode (i_mode),
         .m1   (m1),
         .m2   (m2),
         .a    (i_a[16*k +: 16]),
         .b    (i_b[16*k +: 16]),
         .res  (o_res[16*k +: 16]),
         .ovf  (o_ovf[k]),
         .unf  (o_unf[k]),
         .exc  (o_exc[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_sticky_ovf <= 1'b0;
         o_sticky_unf <= 1'b0;
         o_sticky_exc <= 1'b0;
         o_cnt        <= '0;
      end else begin
         if (fire & |o_ovf)     o_sticky_ovf <= 1'b1;
         else if (i_sticky_clr) o_sticky_ovf <= 1'b0;
         if (fire & |o_unf)     o_sticky_unf <= 1'b1;
         else if (i_sticky_clr) o_sticky_unf <= 1'b0;
         if (fire & |o_exc)     o_sticky_exc <= 1'b1;
         else if (i_sticky_clr) o_sticky_exc <= 1'b0;
         if (fire) o_cnt <= o_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mul_lanes_pipe.sv
// Scoreboard bench for mul_lanes_pipe with hand-computed vectors.
module tb_mul_lanes_pipe;
   import mul_pkg::*;

   localparam int L = 4;
   localparam int W = 16 * L;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_vld, o_rdy, i_mode;
   logic [W-1:0] i_a, i_b, o_res;
   logic         o_vld, i_rdy;
   logic [L-1:0] o_ovf, o_unf, o_exc;
   logic         i_sticky_clr;
   logic         o_sticky_ovf, o_sticky_unf, o_sticky_exc;
   logic [15:0]  o_cnt;

   mul_lanes_pipe #(.LANES(L), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_vld        (i_vld),
      .o_rdy        (o_rdy),
      .i_mode       (i_mode),
      .i_a          (i_a),
      .i_b          (i_b),
      .o_vld        (o_vld),
      .i_rdy        (i_rdy),
      .o_res        (o_res),
      .o_ovf        (o_ovf),
      .o_unf        (o_unf),
      .o_exc        (o_exc),
      .i_sticky_clr (i_sticky_clr),
      .o_sticky_ovf (o_sticky_ovf),
      .o_sticky_unf (o_sticky_unf),
      .o_sticky_exc (o_sticky_exc),
      .o_cnt        (o_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [L-1:0] ovf;
      logic [L-1:0] unf;
      logic [L-1:0] exc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;
   int rx = 0;
   int lat_n;
   int stale;
   bit sends_done;
   logic [W-1:0] held;

   always @(negedge clk) begin
      if (!rst && o_vld && i_rdy) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got res=%h, required no result", o_res);
         end else begin
            mon_e = sb.pop_front();
            if ({o_res, o_ovf, o_unf, o_exc} !== mon_e) begin
               errors++;
               $display("FAIL result[%0d]: got res=%h ovf=%b unf=%b exc=%b, required res=%h ovf=%b unf=%b exc=%b",
                        rx, o_res, o_ovf, o_unf, o_exc,
                        mon_e.res, mon_e.ovf, mon_e.unf, mon_e.exc);
            end
         end
         rx++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic md, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e);
      int n;
      i_vld  = 1'b1;
      i_mode = md;
      i_a    = a;
      i_b    = b;
      n = 0;
      @(negedge clk);
      while (!o_rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!o_rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got o_rdy=0, required 1");
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      i_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rep(input logic [15:0] x);
      return {L{x}};
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      i_vld = 1'b0;
      i_mode = 1'b0;
      i_a = '0;
      i_b = '0;
      i_rdy = 1'b1;
      i_sticky_clr = 1'b0;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_o_vld", o_vld, 0);
      check("rst_o_rdy", o_rdy, 1);
      check("rst_o_cnt", o_cnt, 0);
      check("rst_o_res", o_res, 0);
      check("rst_flags", {o_ovf, o_unf, o_exc}, 0);
      check("rst_sticky", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 0);
      @(posedge clk);
      #1;

      send(MODE_BF16, rep(16'h3FC0), rep(16'h4000),
           {rep(16'h4040), 4'h0, 4'h0, 4'h0});
      lat_n = 0;
      do begin
         @(negedge clk);
         lat_n++;
      end while (!o_vld && lat_n < 20);
      check("latency", lat_n, 3);
      wait_drain();

      send(MODE_BF16, {16'h4040, 16'hC000, 16'h3F81, 16'h3F81},
           {16'h4040, 16'h3F80, 16'h3F81, 16'h3F81},
           {{16'h4110, 16'hC000, 16'h3F82, 16'h3F82}, 4'h0, 4'h0, 4'h0});
      send(MODE_BF16, {16'h8000, 16'h7F80, 16'h0080, 16'h7F00},
           {16'h3F80, 16'h3F80, 16'h0080, 16'h7F00},
           {{16'h8000, 16'h7FC0, 16'h0000, 16'h7F80}, 4'b0001, 4'b0010, 4'b0100});
      send(MODE_BF16, {16'h3F80, 16'h3FB5, 16'h3FC0, 16'h3FC0},
           {16'h3F80, 16'h3FB5, 16'h3F83, 16'h3F81},
           {{16'h3F80, 16'h4000, 16'h3FC4, 16'h3FC2}, 4'h0, 4'h0, 4'h0});
      send(MODE_BF16, {16'hBF80, 16'h3F80, 16'h7F00, 16'h3F00},
           {16'h7F00, 16'h0080, 16'h4000, 16'h0080},
           {{16'hFF00, 16'h0080, 16'h7F80, 16'h0000}, 4'b0010, 4'b0001, 4'h0});
      wait_drain();
      check("cnt_after_bf16", o_cnt, 5);
      check("sticky_set", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 3'b111);
      i_sticky_clr = 1'b1;
      tick(1);
      i_sticky_clr = 1'b0;
      check("sticky_clr", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 3'b000);

      send(MODE_INT8, {16'hAB05, 16'h0010, 16'h0080, 16'h00F6},
           {16'hCD03, 16'h00F0, 16'h0080, 16'h0007},
           {{16'h000F, 16'hFF80, 16'h007F, 16'hFFBA}, 4'b0010, 4'b0100, 4'h0});
      send(MODE_INT8, {16'h00FF, 16'h0008, 16'h0080, 16'h007F},
           {16'h00FF, 16'h0010, 16'h0001, 16'h0001},
           {{16'h0001, 16'h007F, 16'hFF80, 16'h007F}, 4'b0100, 4'h0, 4'h0});
      send(MODE_BF16, rep(16'h4040), rep(16'h4040),
           {rep(16'h4110), 4'h0, 4'h0, 4'h0});
      send(MODE_INT8, rep(16'h4040), rep(16'h4040),
           {rep(16'h007F), 4'hF, 4'h0, 4'h0});
      send(MODE_BF16, rep(16'h3FC0), rep(16'h4000),
           {rep(16'h4040), 4'h0, 4'h0, 4'h0});
      send(MODE_INT8, rep(16'h3FC0), rep(16'h4000),
           {rep(16'h0000), 4'h0, 4'h0, 4'h0});
      wait_drain();
      check("cnt_after_int8", o_cnt, 11);
      check("sticky_int8", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 3'b110);
      i_sticky_clr = 1'b1;
      tick(1);
      i_sticky_clr = 1'b0;

      i_rdy = 1'b0;
      send(MODE_INT8, rep(16'h0080), rep(16'h0080),
           {rep(16'h007F), 4'hF, 4'h0, 4'h0});
      lat_n = 0;
      while (!o_vld && lat_n < 20) begin
         @(negedge clk);
         lat_n++;
      end
      check("setwins_o_vld", o_vld, 1);
      @(posedge clk);
      #1;
      i_rdy = 1'b1;
      i_sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      i_rdy = 1'b0;
      i_sticky_clr = 1'b0;
      check("sticky_set_wins", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 3'b100);
      check("cnt_setwins", o_cnt, 12);
      i_rdy = 1'b1;

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("cnt_after_rst", o_cnt, 0);
      i_rdy = 1'b0;
      send(MODE_BF16, rep(16'h3FC0), rep(16'h4000),
           {rep(16'h4040), 4'h0, 4'h0, 4'h0});
      send(MODE_BF16, rep(16'h3F81), rep(16'h3F81),
           {rep(16'h3F82), 4'h0, 4'h0, 4'h0});
      send(MODE_INT8, {16'hAB05, 16'h0010, 16'h0080, 16'h00F6},
           {16'hCD03, 16'h00F0, 16'h0080, 16'h0007},
           {{16'h000F, 16'hFF80, 16'h007F, 16'hFFBA}, 4'b0010, 4'b0100, 4'h0});
      @(negedge clk);
      check("bp_o_rdy_low", o_rdy, 0);
      check("bp_o_vld", o_vld, 1);
      held = o_res;
      sends_done = 1'b0;
      fork
         begin
            send(MODE_INT8, rep(16'h00F6), rep(16'h0007),
                 {rep(16'hFFBA), 4'h0, 4'h0, 4'h0});
            send(MODE_BF16, rep(16'h7F00), rep(16'h7F00),
                 {rep(16'h7F80), 4'hF, 4'h0, 4'h0});
            sends_done = 1'b1;
         end
      join_none
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold_%0d", i), o_res, held);
      end
      check("bp_still_full", o_rdy, 0);
      @(posedge clk);
      #1;
      i_rdy = 1'b1;
      lat_n = 0;
      while (!sends_done && lat_n < 50) begin
         @(negedge clk);
         lat_n++;
      end
      check("bp_sends_done", sends_done, 1);
      wait_drain();
      check("bp_cnt", o_cnt, 5);

      send(MODE_BF16, rep(16'h3FC0), rep(16'h4000),
           {rep(16'h4040), 4'h0, 4'h0, 4'h0});
      send(MODE_BF16, rep(16'h3F81), rep(16'h3F81),
           {rep(16'h3F82), 4'h0, 4'h0, 4'h0});
      @(posedge clk);
      #1;
      check("pre_rst_o_vld", o_vld, 1);
      check("pre_rst_sticky", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 3'b110);
      rst = 1'b1;
      #1;
      sb.delete();
      check("midrst_o_vld", o_vld, 0);
      check("midrst_o_cnt", o_cnt, 0);
      check("midrst_flags", {o_ovf, o_unf, o_exc}, 0);
      check("midrst_sticky", {o_sticky_ovf, o_sticky_unf, o_sticky_exc}, 0);
      check("midrst_o_res", o_res, 0);
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_o_rdy", o_rdy, 1);
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_vld) stale++;
      end
      check("no_stale_result", stale, 0);
      check("post_rst_cnt", o_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
